// File: rtl/dmux_pkg.sv
// Shared types and constants for the 1x4 dispatch controller.
// Imported by the interface-side RTL and the bench.
package dmux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_DIR = 1'b1;

    function automatic logic [3:0] onehot4(input logic [1:0] ch);
        return 4'b0001 << ch;
    endfunction

endpackage

// File: rtl/dmux_dispatch_ctrl_if.sv
// Handshake bundle between the producer/consumers and the dispatcher.
// master = environment side, slave = dispatcher side.
interface dmux_dispatch_ctrl_if #(
    parameter int DW    = 4,
    parameter int CNT_W = 8
);
    logic             mode;
    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic [1:0]       in_dest;
    logic             in_ready;
    logic [DW-1:0]    a;
    logic [DW-1:0]    b;
    logic [DW-1:0]    c;
    logic [DW-1:0]    d;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [1:0]       sel;
    logic [4*CNT_W-1:0] deliv_cnt;

    modport master (
        output mode, in_valid, in_data, in_dest, out_ready,
        input  in_ready, a, b, c, d, out_valid, sel, deliv_cnt
    );

    modport slave (
        input  mode, in_valid, in_data, in_dest, out_ready,
        output in_ready, a, b, c, d, out_valid, sel, deliv_cnt
    );
endinterface

// File: rtl/dmux_route_1x4.sv
// Combinational 1x4 demux: enabled input word appears on the selected lane only.
module dmux_route_1x4
    import dmux_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          i_en,
    input  logic [1:0]    i_sel,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_a,
    output logic [DW-1:0] o_b,
    output logic [DW-1:0] o_c,
    output logic [DW-1:0] o_d
);

    always_comb begin
        o_a = '0;
        o_b = '0;
        o_c = '0;
        o_d = '0;
        if (i_en) begin
            unique case (1'b1)
                (i_sel == CH_A): o_a = i_data;
                (i_sel == CH_B): o_b = i_data;
                (i_sel == CH_C): o_c = i_data;
                (i_sel == CH_D): o_d = i_data;
                default:         o_a = '0;
            endcase
        end
    end

endmodule

// File: rtl/dmux_dispatch_ctrl.sv
// One-word buffered 1x4 dispatcher: round-robin or directed target, RR timeout re-target.
// Optional per-channel saturating delivery counters under STAT_CNT_EN.
module dmux_dispatch_ctrl
    import dmux_pkg::*;
#(
    parameter int DW      = 4,
    parameter int TIMEOUT = 4,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    dmux_dispatch_ctrl_if.slave bus
);

    localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_buf;
    logic [1:0]    r_sel;
    logic [1:0]    r_rr_ptr;
    logic          r_mode;
    logic [SW-1:0] r_stall;

    logic          w_full;
    logic          w_deliver;
    logic          w_in_ready;
    logic          w_latch;
    logic          w_timeout;
    logic [1:0]    w_rr_now;
    logic [1:0]    w_tgt;

    assign w_full     = (r_state == FULL);
    assign w_deliver  = w_full & bus.out_ready[r_sel];
    assign w_in_ready = ~w_full | bus.out_ready[r_sel];
    assign w_latch    = bus.in_valid & w_in_ready;

    // back-to-back: the pointer is moving this very cycle, use its next value
    assign w_rr_now = w_deliver ? (r_sel + 2'd1) : r_rr_ptr;
    assign w_tgt    = (bus.mode == MODE_DIR) ? bus.in_dest : w_rr_now;

    assign w_timeout = w_full & ~w_deliver & (r_mode == MODE_RR)
                     & (r_stall == STALL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            EMPTY: if (bus.in_valid) w_state_nxt = FULL;
            FULL:  if (w_deliver && !bus.in_valid) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        bus.in_ready  = w_in_ready;
        bus.out_valid = '0;
        if (w_full) bus.out_valid = onehot4(r_sel);
        bus.sel       = r_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf   <= '0;
            r_sel   <= CH_A;
            r_mode  <= MODE_RR;
            r_stall <= '0;
        end else if (w_latch) begin
            r_buf   <= bus.in_data;
            r_sel   <= w_tgt;
            r_mode  <= bus.mode;
            r_stall <= '0;
        end else if (w_deliver) begin
            r_stall <= '0;
        end else if (w_timeout) begin
            r_sel   <= r_sel + 2'd1;
            r_stall <= '0;
        end else if (w_full && r_mode == MODE_RR) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_rr_ptr <= CH_A;
        else if (w_deliver) r_rr_ptr <= r_sel + 2'd1;
    end

    dmux_route_1x4 #(.DW(DW)) u_route (
        .i_en   (w_full),
        .i_sel  (r_sel),
        .i_data (r_buf),
        .o_a    (bus.a),
        .o_b    (bus.b),
        .o_c    (bus.c),
        .o_d    (bus.d)
    );

`ifdef STAT_CNT_EN
    logic [CNT_W-1:0] r_cnt [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_deliver && r_sel == 2'(i) && r_cnt[i] != '1)
                    r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign bus.deliv_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
    end
`else
    assign bus.deliv_cnt = '0;
`endif

endmodule

// File: tb/tb_dmux_dispatch_ctrl.sv
// Directed-vector bench for dmux_dispatch_ctrl (DW=4, TIMEOUT=4).
// Build with STAT_CNT_EN to exercise saturating counters at CNT_W=2.
module tb_dmux_dispatch_ctrl;
    import dmux_pkg::*;

`ifdef STAT_CNT_EN
    localparam int CW = 2;
    localparam logic [31:0] CNT_EXP = 32'h3;
`else
    localparam int CW = 8;
    localparam logic [31:0] CNT_EXP = 32'h0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmux_dispatch_ctrl_if #(.DW(4), .CNT_W(CW)) bus ();

    dmux_dispatch_ctrl #(.DW(4), .TIMEOUT(4), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.mode      = MODE_RR;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_dest   = '0;
        bus.out_ready = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_lanes", 32'({bus.d, bus.c, bus.b, bus.a}), 32'h0);

        // reset while FULL
        bus.in_valid = 1'b1;
        bus.in_data  = 4'hA;
        tick();
        bus.in_valid = 1'b0;
        chk("t1_valid", 32'(bus.out_valid), 32'h1);
        chk("t1_a", 32'(bus.a), 32'hA);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("t1_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("t1_rst_lanes", 32'({bus.d, bus.c, bus.b, bus.a}), 32'h0);
        chk("t1_rst_sel", 32'(bus.sel), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // round-robin stream
        bus.out_ready = 4'hF;
        bus.mode      = MODE_RR;
        bus.in_valid  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus.in_data = 4'(i);
            #1;
            chk("t2_in_ready", 32'(bus.in_ready), 32'h1);
            tick();
            chk("t2_valid", 32'(bus.out_valid), 32'(4'b0001 << ((i - 1) % 4)));
            chk("t2_lanes", 32'({bus.d, bus.c, bus.b, bus.a}),
                32'(i) << (4 * ((i - 1) % 4)));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("t2_empty", 32'(bus.out_valid), 32'h0);

        // directed, long stall, no re-target
        bus.mode      = MODE_DIR;
        bus.in_dest   = 2'd2;
        bus.in_data   = 4'h7;
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("t3_valid", 32'(bus.out_valid), 32'h4);
            chk("t3_c", 32'(bus.c), 32'h7);
            tick();
        end
        chk("t3_in_ready_hold", 32'(bus.in_ready), 32'h0);
        bus.out_ready = 4'b0100;
        #1;
        chk("t3_in_ready_rel", 32'(bus.in_ready), 32'h1);
        tick();
        chk("t3_done", 32'(bus.out_valid), 32'h0);

        // one directed word to a, so round-robin resumes at b
        bus.in_dest   = 2'd0;
        bus.in_data   = 4'h9;
        bus.out_ready = 4'hF;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("t4_pre_a", 32'(bus.a), 32'h9);
        tick();

        // RR timeout re-target b -> c
        bus.mode      = MODE_RR;
        bus.out_ready = 4'b0000;
        bus.in_data   = 4'h5;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t4_on_b", 32'(bus.out_valid), 32'h2);
            tick();
        end
        chk("t4_on_c", 32'(bus.out_valid), 32'h4);
        chk("t4_c", 32'(bus.c), 32'h5);
        chk("t4_sel", 32'(bus.sel), 32'h2);
        bus.out_ready = 4'b0100;
        tick();
        chk("t4_done", 32'(bus.out_valid), 32'h0);
        bus.out_ready = 4'hF;
        bus.in_data   = 4'h3;
        bus.in_valid  = 1'b1;
        tick();
        chk("t4_rr_ptr_d", 32'(bus.out_valid), 32'h8);
        chk("t4_d", 32'(bus.d), 32'h3);

        // backpressure with pending input
        bus.out_ready = 4'b0000;
        bus.in_data   = 4'h6;
        #1;
        chk("t5_in_ready0", 32'(bus.in_ready), 32'h0);
        tick();
        chk("t5_hold_valid", 32'(bus.out_valid), 32'h8);
        chk("t5_hold_d", 32'(bus.d), 32'h3);
        bus.out_ready = 4'b1000;
        #1;
        chk("t5_in_ready1", 32'(bus.in_ready), 32'h1);
        tick();
        chk("t5_next_valid", 32'(bus.out_valid), 32'h1);
        chk("t5_next_a", 32'(bus.a), 32'h6);
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'hF;
        tick();
        chk("t5_done", 32'(bus.out_valid), 32'h0);

        // counters: fresh reset, five deliveries to a
        rst_n = 1'b0;
        #1;
        chk("t6_rst_cnt", 32'(bus.deliv_cnt), 32'h0);
        tick();
        rst_n = 1'b1;
        bus.mode     = MODE_DIR;
        bus.in_dest  = 2'd0;
        bus.in_data  = 4'h1;
        bus.in_valid = 1'b1;
        repeat (5) tick();
        bus.in_valid = 1'b0;
        tick();
        chk("t6_cnt", 32'(bus.deliv_cnt), CNT_EXP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
